// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester unified memory port arbiter.
package mem_arb_pkg;

    // Arbiter FSM states, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Requester identifiers; also the encoding of last_grant.
    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_t;

    // A fetch is misaligned when it does not point at a word boundary.
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, data and downstream memory handshakes around the arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    // Fetch side
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              if_err;
    // Load/store side
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [STRB_W-1:0] d_wstrb;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    // Downstream memory port
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter view: accepts upstream requests, drives the memory port.
    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata, if_err,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    // Environment view: requesters and memory model.
    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick; the last_grant flop lives in the parent.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic    req_if,
    input  logic    req_d,
    input  req_id_t last_grant,
    output logic    gnt_if,
    output logic    gnt_d
);

    // A lone requester wins; on a tie the side opposite last_grant wins.
    assign gnt_if = req_if && (!req_d || (last_grant == REQ_D));
    assign gnt_d  = req_d  && (!req_if || (last_grant == REQ_IF));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and load/store, one transaction at a time,
// round-robin on ties; misaligned fetches are answered with an error, no memory access.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam int STRB_W = DATA_W / 8;

    state_t            state, state_nxt;
    req_id_t           last_grant;
    req_id_t           cap_id;
    logic              cap_we;
    logic              cap_err;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic [DATA_W-1:0] cap_rdata;
    logic [STRB_W-1:0] cap_wstrb;

    logic pick_if, pick_d;
    logic win, win_misaligned;

    rr_pick2 u_pick (
        .req_if     (bus.if_req),
        .req_d      (bus.d_req),
        .last_grant (last_grant),
        .gnt_if     (pick_if),
        .gnt_d      (pick_d)
    );

    assign win            = (state == ST_IDLE) && (pick_if || pick_d);
    assign win_misaligned = (state == ST_IDLE) && pick_if && is_misaligned(bus.if_addr[1:0]);

    // The downstream payload comes straight from the capture registers, so it
    // cannot move while ISSUE is stalled on mem_gnt.
    assign bus.mem_we    = cap_we;
    assign bus.mem_addr  = cap_addr;
    assign bus.mem_wdata = cap_wdata;
    assign bus.mem_wstrb = cap_wstrb;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            // NOTE: flops use non-blocking assignment so every register samples
            // the pre-edge values, independent of statement order.
            state <= state_nxt;
        end
    end

    // Next-state decode plus grant, response and memory-request outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned
        // (which would infer a latch).
        state_nxt     = state;
        bus.if_gnt    = 1'b0;
        bus.d_gnt     = 1'b0;
        bus.if_rvalid = 1'b0;
        bus.if_rdata  = '0;
        bus.if_err    = 1'b0;
        bus.d_rvalid  = 1'b0;
        bus.d_rdata   = '0;
        bus.mem_req   = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.if_gnt = pick_if;
                bus.d_gnt  = pick_d;
                if (pick_if || pick_d) begin
                    state_nxt = win_misaligned ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                bus.mem_req = 1'b1;
                if (bus.mem_gnt) begin
                    state_nxt = cap_we ? ST_RESP : ST_WAIT_R;
                end
            end
            ST_WAIT_R: begin
                if (bus.mem_rvalid) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (cap_id == REQ_IF) begin
                    bus.if_rvalid = 1'b1;
                    bus.if_rdata  = cap_rdata;
                    bus.if_err    = cap_err;
                end else begin
                    bus.d_rvalid = 1'b1;
                    bus.d_rdata  = cap_rdata;
                end
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Capture the winner's request at grant time and the read data on return.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: capture registers are reset too, because they drive the
            // mem_* outputs directly and those must read 0 out of reset.
            last_grant <= REQ_D;
            cap_id     <= REQ_IF;
            cap_we     <= 1'b0;
            cap_err    <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            cap_rdata  <= '0;
            cap_wstrb  <= '0;
        end else if (win) begin
            last_grant <= pick_if ? REQ_IF : REQ_D;
            cap_id     <= pick_if ? REQ_IF : REQ_D;
            cap_we     <= pick_d && bus.d_we;
            cap_err    <= win_misaligned;
            cap_addr   <= pick_if ? bus.if_addr : bus.d_addr;
            cap_wdata  <= pick_d ? bus.d_wdata : '0;
            cap_wstrb  <= pick_d ? bus.d_wstrb : '0;
            cap_rdata  <= '0;
        end else if ((state == ST_WAIT_R) && bus.mem_rvalid) begin
            cap_rdata  <= bus.mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model + directed scenarios.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- memory model ----------------
    int          stall_left  = 0;
    logic        hold_return = 1'b0;
    logic        auto_rv     = 1'b0;
    logic [31:0] rv_data     = '0;
    logic        spur        = 1'b0;
    logic [31:0] spur_data   = '0;
    logic        mem_dec     = 1'b0;
    logic        mem_ret     = 1'b0;
    logic [31:0] ret_addr    = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'h0000_0013;
        return {16'hA5A5, a[15:0]};
    endfunction

    assign bus.mem_gnt    = bus.mem_req && (stall_left == 0);
    assign bus.mem_rvalid = auto_rv | spur;
    assign bus.mem_rdata  = spur ? spur_data : rv_data;

    // Memory returns read data the cycle after it accepts a read.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            auto_rv = 1'b0;
        end else begin
            if (mem_dec) stall_left--;
            auto_rv = mem_ret;
            rv_data = mem_word(ret_addr);
        end
    end

    // ---------------- reference model + logs ----------------
    int      cyc = 0;
    bit      m_busy, m_pend, m_wait, m_resp;
    req_id_t m_last, m_owner;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic        m_we, m_err;
    logic        e_if, e_d, nxt, acc;

    int gnt_log[$];
    int if_gnt_cyc, d_gnt_cyc, mem_gnt_cyc, if_rv_cyc, d_rv_cyc;
    int mem_req_cnt = 0;
    int rv_cnt      = 0;
    logic [31:0] log_if_rdata, log_d_rdata, log_mem_addr, log_mem_wdata;
    logic [3:0]  log_mem_wstrb;
    logic        log_if_err;

    // Cycle counter for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    // Compare DUT outputs against the model every cycle, then advance the model.
    always @(negedge clk) begin
        if (!rst) begin
            check("reset_outputs",
                  {bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.if_err, bus.d_gnt, bus.d_rvalid,
                   bus.d_rdata, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb},
                  '0);
            m_busy = 0; m_pend = 0; m_wait = 0; m_resp = 0; m_last = REQ_D;
            mem_dec = 0; mem_ret = 0;
        end else begin
            e_if = !m_busy && bus.if_req && (!bus.d_req || m_last == REQ_D);
            e_d  = !m_busy && bus.d_req  && (!bus.if_req || m_last == REQ_IF);
            check("if_gnt", bus.if_gnt, e_if);
            check("d_gnt", bus.d_gnt, e_d);
            check("one_gnt", bus.if_gnt & bus.d_gnt, 1'b0);
            check("mem_req", bus.mem_req, m_pend);
            if (m_pend) begin
                check("mem_addr", bus.mem_addr, m_addr);
                check("mem_we", bus.mem_we, m_we);
                check("mem_wdata", bus.mem_wdata, m_wdata);
                check("mem_wstrb", bus.mem_wstrb, m_wstrb);
            end
            check("if_rvalid", bus.if_rvalid, m_resp && (m_owner == REQ_IF));
            check("d_rvalid", bus.d_rvalid, m_resp && (m_owner == REQ_D));
            check("one_rvalid", bus.if_rvalid & bus.d_rvalid, 1'b0);
            if (m_resp && m_owner == REQ_IF) begin
                check("if_rdata", bus.if_rdata, m_rdata);
                check("if_err", bus.if_err, m_err);
            end
            if (m_resp && m_owner == REQ_D) check("d_rdata", bus.d_rdata, m_rdata);

            if (bus.if_gnt) begin gnt_log.push_back(0); if_gnt_cyc = cyc; end
            if (bus.d_gnt)  begin gnt_log.push_back(1); d_gnt_cyc  = cyc; end
            if (bus.mem_req) begin
                mem_req_cnt++;
                log_mem_addr  = bus.mem_addr;
                log_mem_wdata = bus.mem_wdata;
                log_mem_wstrb = bus.mem_wstrb;
                if (bus.mem_gnt) mem_gnt_cyc = cyc;
            end
            if (bus.if_rvalid) begin
                rv_cnt++; if_rv_cyc = cyc; log_if_rdata = bus.if_rdata; log_if_err = bus.if_err;
            end
            if (bus.d_rvalid) begin
                rv_cnt++; d_rv_cyc = cyc; log_d_rdata = bus.d_rdata;
            end

            nxt = 0;
            acc = m_pend && (stall_left == 0);
            if (e_if || e_d) begin
                m_busy  = 1;
                m_owner = e_if ? REQ_IF : REQ_D;
                m_last  = m_owner;
                m_addr  = e_if ? bus.if_addr : bus.d_addr;
                m_we    = e_d && bus.d_we;
                m_wdata = e_d ? bus.d_wdata : '0;
                m_wstrb = e_d ? bus.d_wstrb : '0;
                m_rdata = '0;
                m_err   = e_if && (bus.if_addr[1:0] != 2'b00);
                if (m_err) nxt = 1; else m_pend = 1;
            end else if (acc) begin
                m_pend = 0;
                if (m_we) nxt = 1; else m_wait = 1;
            end else if (m_wait && bus.mem_rvalid) begin
                m_wait  = 0;
                m_rdata = bus.mem_rdata;
                nxt     = 1;
            end
            if (m_resp) m_busy = 0;
            m_resp = nxt;

            mem_dec  = bus.mem_req && (stall_left > 0);
            mem_ret  = bus.mem_req && bus.mem_gnt && !bus.mem_we && !hold_return;
            ret_addr = bus.mem_addr;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_gnt(input int who);
        bit found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (who == 0 ? bus.if_gnt : bus.d_gnt) found = 1;
        end
        check(who == 0 ? "if_gnt_timeout" : "d_gnt_timeout", found, 1'b1);
    endtask

    task automatic wait_rv(input int who);
        bit found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (who == 0 ? bus.if_rvalid : bus.d_rvalid) found = 1;
        end
        check(who == 0 ? "if_rvalid_timeout" : "d_rvalid_timeout", found, 1'b1);
    endtask

    task automatic wait_quiet();
        bit found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk); #3;
            if (!m_busy) found = 1;
        end
        check("idle_timeout", found, 1'b1);
    endtask

    task automatic wait_log(input int n);
        bit found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(posedge clk); #3;
            if (gnt_log.size() >= n) found = 1;
        end
        check("grant_count_timeout", found, 1'b1);
    endtask

    task automatic do_fetch(input logic [31:0] a);
        @(posedge clk); #2;
        bus.if_req = 1'b1; bus.if_addr = a;
        wait_gnt(0);
        @(posedge clk); #2;
        bus.if_req = 1'b0;
        wait_rv(0);
        repeat (2) @(posedge clk);
    endtask

    task automatic do_data(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] strb, input int stall);
        @(posedge clk); #2;
        stall_left = stall;
        bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd; bus.d_wstrb = strb;
        wait_gnt(1);
        @(posedge clk); #2;
        bus.d_req = 1'b0;
        wait_rv(1);
        repeat (2) @(posedge clk);
    endtask

    // ---------------- directed scenarios ----------------
    int snap, rv_snap;

    initial begin
        bus.if_req = 0; bus.if_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_wstrb = '0;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;

        // Aligned fetch: 3-cycle latency, data from memory.
        do_fetch(32'h100);
        check("t1_latency", if_rv_cyc - if_gnt_cyc, 3);
        check("t1_rdata", log_if_rdata, 32'h0000_0013);
        check("t1_err", log_if_err, 1'b0);
        check("t1_mem_addr", log_mem_addr, 32'h100);

        // Misaligned fetch: error response next cycle, memory untouched.
        snap = mem_req_cnt;
        do_fetch(32'h102);
        check("t3_no_mem_req", mem_req_cnt - snap, 0);
        check("t3_latency", if_rv_cyc - if_gnt_cyc, 1);
        check("t3_err", log_if_err, 1'b1);
        check("t3_rdata", log_if_rdata, 32'h0);

        // Write with 3 stall cycles on mem_gnt.
        snap = mem_req_cnt;
        do_data(1'b1, 32'h300, 32'hDEAD_BEEF, 4'b0011, 3);
        check("t4_issue_cycles", mem_req_cnt - snap, 4);
        check("t4_resp_after_gnt", d_rv_cyc - mem_gnt_cyc, 1);
        check("t4_rdata", log_d_rdata, 32'h0);
        check("t4_wdata", log_mem_wdata, 32'hDEAD_BEEF);
        check("t4_wstrb", log_mem_wstrb, 4'b0011);
        check("t4_addr", log_mem_addr, 32'h300);

        // Both requesting continuously: grants alternate, starting with fetch.
        gnt_log.delete();
        @(posedge clk); #2;
        bus.if_req = 1; bus.if_addr = 32'h0;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200;
        wait_log(4);
        bus.if_req = 0; bus.d_req = 0;
        wait_quiet();
        if (gnt_log.size() >= 4) begin
            check("t2_grant0", gnt_log[0], 0);
            check("t2_grant1", gnt_log[1], 1);
            check("t2_grant2", gnt_log[2], 0);
            check("t2_grant3", gnt_log[3], 1);
        end
        check("t2_grant_spacing", d_gnt_cyc - if_gnt_cyc, 4);
        check("t2_d_rdata", log_d_rdata, 32'hA5A5_0200);

        // Spurious mem_rvalid in IDLE is ignored; next fetch behaves normally.
        rv_snap = rv_cnt;
        @(posedge clk); #2;
        spur = 1; spur_data = 32'h0000_0BAD;
        @(posedge clk); #2;
        spur = 0;
        repeat (2) @(posedge clk);
        check("t6_no_resp", rv_cnt - rv_snap, 0);
        do_fetch(32'h104);
        check("t6_latency", if_rv_cyc - if_gnt_cyc, 3);
        check("t6_rdata", log_if_rdata, 32'hA5A5_0104);

        // Reset during WAIT_R, then a stale return.
        hold_return = 1;
        @(posedge clk); #2;
        bus.if_req = 1; bus.if_addr = 32'h180;
        wait_gnt(0);
        @(posedge clk); #2;
        bus.if_req = 0;
        @(posedge clk); #2;
        rv_snap = rv_cnt;
        rst = 0;
        #1;
        check("t5_async_clear",
              {bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.if_err, bus.d_gnt, bus.d_rvalid,
               bus.d_rdata, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb},
              '0);
        @(posedge clk); #2;
        rst = 1;
        spur = 1; spur_data = 32'h0000_0055;
        @(posedge clk); #2;
        spur = 0; hold_return = 0;
        repeat (3) @(posedge clk);
        check("t5_stale_ignored", rv_cnt - rv_snap, 0);
        gnt_log.delete();
        @(posedge clk); #2;
        bus.if_req = 1; bus.if_addr = 32'h0;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200;
        wait_log(1);
        bus.if_req = 0;
        if (gnt_log.size() >= 1) check("t5_tie_to_if", gnt_log[0], 0);
        wait_gnt(1);
        @(posedge clk); #2;
        bus.d_req = 0;
        wait_quiet();
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the core's single unified memory port between the instruction-fetch unit and the load/store unit. It sits between the core pipeline and the memory model. It serialises accesses with one transaction outstanding and round-robin priority. It also traps misaligned fetch addresses without touching memory, so that fetch faults are reported with a defined response.

## Interface
- `ADDR_W`, default 32: address width, byte addressing.
- `DATA_W`, default 32: data width; `DATA_W/8` byte strobes.

Ports:
- `clk` in 1: the single clock; all flops rise-edge.
- `rst` in 1: asynchronous, active-low reset; 0 clears all state immediately.
- `if_req` in 1: fetch request.
- `if_addr` in ADDR_W: fetch address.
- `if_gnt` out 1: fetch request accepted this cycle.
- `if_rvalid` out 1: one-cycle fetch response pulse.
- `if_rdata` out DATA_W: fetched word.
- `if_err` out 1: misaligned-fetch flag, valid with `if_rvalid`.
- `d_req` in 1: data request.
- `d_we` in 1: 1 = write.
- `d_addr` in ADDR_W: data address.
- `d_wdata` in DATA_W: store data.
- `d_wstrb` in DATA_W/8: byte enables.
- `d_gnt` out 1: data request accepted.
- `d_rvalid` out 1: data response pulse; for writes, this is completion.
- `d_rdata` out DATA_W: load data; 0 for writes.
- `mem_req` out 1: downstream request, held until `mem_gnt`.
- `mem_we` out 1: downstream write.
- `mem_addr` out ADDR_W: downstream address.
- `mem_wdata` out DATA_W: downstream write data.
- `mem_wstrb` out DATA_W/8: downstream byte enables.
- `mem_gnt` in 1: memory accepted the request.
- `mem_rvalid` in 1: read data valid.
- `mem_rdata` in DATA_W: read data.

## Operation
States:
- `IDLE`: ready to arbitrate.
- `ISSUE`: `mem_req` is held high.
- `WAIT_R`: waiting for `mem_rvalid`.
- `RESP`: the registered upstream response is driven for exactly one cycle.

In `IDLE`:
- Arbitration:
  - If only one requester is high, it wins.
  - If both are high, the winner is the one opposite `last_grant`.
  - `last_grant` resets to "data", so fetch wins the first tie.
- Winner handling:
  - The winner's `*_gnt` is asserted combinationally in the same cycle.
  - The winner's address, write-enable, write data, strobes and id are captured.
  - `last_grant` updates to the winner.
- Misaligned fetch: if the winner is fetch and `if_addr[1:0] != 0`, there is no memory access. The next state is `RESP` with `err=1` and `rdata=0`.
- Otherwise the next state is `ISSUE`.

In `ISSUE`:
- `mem_req=1` and the `mem_*` outputs are driven from the captured registers.
- On `mem_gnt`:
  - Write: go to `RESP` with `rdata=0`.
  - Read: go to `WAIT_R`.

In `WAIT_R`:
- On `mem_rvalid`, capture `mem_rdata` and go to `RESP`.

In `RESP`:
- Pulse the owner's `*_rvalid`, `*_rdata` and (fetch only) `if_err`, then return to `IDLE`.
- Both `*_gnt` outputs are 0 in `RESP`; a new grant is possible only in the following `IDLE` cycle.

Other rules:
- `mem_rvalid` outside `WAIT_R` is ignored; this includes a stale return after reset.
- Upstream requesters must hold `*_req` and their payload stable until `*_gnt`.
- The non-winner is not granted and must keep requesting.
- `*_gnt` is never asserted outside `IDLE`.
- At most one `*_gnt` is high in any cycle.
- At most one `*_rvalid` is high in any cycle.
- The arbiter never asserts `mem_req` for a misaligned fetch.
- Data-side alignment is not checked; strobes pass through unchanged.

## Timing
- Reset values:
  - All outputs are 0.
  - State is `IDLE`.
  - `last_grant` is "data".
  - Capture registers are 0.
- Assertion of `rst=0` mid-transaction aborts to `IDLE` immediately; `mem_req` drops without waiting for `mem_gnt`.
- Read latency, with a memory that grants immediately and returns data the next cycle:
  - Cycle 0: `gnt`.
  - Cycle 1: `mem_req` with `mem_gnt`.
  - Cycle 2: `mem_rvalid`.
  - Cycle 3: upstream `rvalid`.
  - Next `gnt` is possible in cycle 4.
- Write latency: `gnt` in cycle 0, `mem_gnt` in cycle 1, `d_rvalid` in cycle 2.
- Misaligned fetch: `if_gnt` in cycle 0, then `if_rvalid` with `if_err=1` in cycle 1.
- `mem_gnt` stalls extend `ISSUE` indefinitely; `mem_*` outputs stay stable throughout.

## Structure
- Shared package/header `mem_arb_pkg`:
  - State encoding `ST_IDLE`, `ST_ISSUE`, `ST_WAIT_R`, `ST_RESP` (2 bits).
  - Requester ids `REQ_IF=0`, `REQ_D=1`.
- One sub-module, `rr_pick2`: a combinational two-way round-robin pick from `{req_if, req_d, last_grant}` to `{gnt_if, gnt_d}`. The `last_grant` flop stays in the parent.

## Test plan
- Reset then a fetch read of 0x100 with memory returning 0x00000013 → `if_gnt` in cycle 0, `mem_addr=0x100`, `if_rvalid` and `if_rdata=0x00000013` in cycle 3, `if_err=0`.
- `if_req` and `d_req` held continuously (fetch 0x0, data read 0x200) → grants alternate IF, D, IF, D starting with IF; never two `*_rvalid` in one cycle.
- Fetch 0x102 → `if_gnt`, no `mem_req` ever, `if_rvalid=1`, `if_err=1`, `if_rdata=0` one cycle later.
- Data write of 0xDEADBEEF to 0x300 with `wstrb=4'b0011`, `mem_gnt` held low for 3 cycles → `mem_*` stable for 4 cycles, `d_rvalid` one cycle after `mem_gnt`, `d_rdata=0`.
- `rst` pulsed low during `WAIT_R`, then `mem_rvalid` arrives → all outputs 0 at once, the stale `mem_rvalid` is ignored, and the next tie is granted to IF.
- Spurious `mem_rvalid` in `IDLE` → no upstream `rvalid`, state unchanged.
